load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Takes the ALU result as the effective address, plus rs2 store data, width/sign code and direction from decode.
- Runs a req/ack transaction to data memory, aligns store bytes, and sign/zero-extends load data for writeback.
- Stalls the pipeline via `busy` until the access completes or times out.

Parameters:
DATA_WIDTH, 32, data/address width; only 32 supported
TIMEOUT_CYCLES, 15, max cycles waiting for mem_ack in REQ; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
start  in  1  access request, sampled in IDLE only
MemWrite  in  1  1 = store, 0 = load
funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResult  in  32  effective byte address
WriteData  in  32  store data (rs2)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
error  out  1  valid with done; 1 = access failed
ReadData  out  32  extended load result; held until next successful load
mem_req  out  1  memory request
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  32  word address: ALUResult with [1:0] forced to 00
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables, bit i = byte lane i
mem_ack  in  1  memory completion, single cycle
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset (async, any state): state = IDLE. All outputs = 0, including ReadData. Timeout counter = 0. mem_req drops immediately on reset assertion.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On start=1, register MemWrite, funct3, ALUResult and WriteData.
  - Valid access: go to REQ.
  - Invalid access: go straight to DONE with error=1 and no memory access.
  - Invalid means: load funct3 in {011, 110, 111}; store funct3 not in {000, 001, 010}.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_wdata, mem_be all held stable.
  - Counter increments each cycle spent in REQ.
  - mem_ack=1: for loads, capture the extended mem_rdata into ReadData; go to DONE with error=0.
  - Timeout: counter reaches TIMEOUT_CYCLES with no ack → DONE, error=1, ReadData unchanged.
  - If ack arrives on the timeout cycle, ack wins.
- DONE: done=1 for exactly one cycle; error valid; then IDLE. Counter cleared.
- start while busy is ignored. It is not queued.
- mem_ack outside REQ is ignored.
- Latency: start in cycle 0 → mem_req in cycle 1 → ack in cycle 1 gives done in cycle 2. Each extra wait cycle adds 1.
- Byte lanes: little-endian, lane = ALUResult[1:0].
- Stores:
  - SB: be = 1 << lane; wdata = WriteData[7:0] replicated ×4.
  - SH: be = 0011 if addr[1]=0, else 1100; wdata = WriteData[15:0] replicated ×2.
  - SW: be = 1111; wdata = WriteData.
- Loads: mem_be=0000 during loads.
  - B/BU: select byte at lane; sign- or zero-extend to 32.
  - H/HU: select half by addr[1]; extend.
  - W: full word.
- Misalignment handling without the macro: halfword ignores addr[0]; word ignores addr[1:0].

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access goes IDLE→DONE with error=1 and no mem_req.
  - Misaligned means: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=00.
  - done arrives in cycle 1.
- Undefined: no misalignment check; low address bits are truncated as above.

Test Plan:
- LW, ALUResult=0x100, ack in cycle 1, mem_rdata=0xDEADBEEF → mem_addr=0x100, be=0000, done in cycle 2, ReadData=0xDEADBEEF, error=0.
- LB, addr=0x103, mem_rdata=0x80112233 → ReadData=0xFFFFFF80; same access as LBU → 0x00000080.
- SH, addr=0x202, WriteData=0x1234ABCD, ack after 3 wait cycles → mem_we=1, be=1100, wdata=0xABCDABCD, done in cycle 5.
- LW with mem_ack never asserted, TIMEOUT_CYCLES=15 → mem_req high for 15 cycles, then done with error=1, ReadData unchanged.
- start pulsed again during REQ, then rst_n=0 mid-REQ → second start ignored; on reset mem_req/busy/done=0 immediately, and the next start behaves normally.
- LSU_MISALIGN_TRAP_EN defined, LW addr=0x101 → no mem_req, done+error in cycle 1. Undefined → mem_addr=0x100, normal completion.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store stage: req/ack access to data memory with store lane alignment and load extension.
// Define LSU_MISALIGN_TRAP_EN to fail misaligned halfword/word accesses instead of truncating the address.
//
// state | meaning
// IDLE  | waiting for start; decodes and latches the access
// REQ   | mem_req held, waiting for mem_ack or timeout
// DONE  | one-cycle done pulse with error status
module load_store_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  MemWrite,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [15:0] TIMEOUT_TC = TIMEOUT_CYCLES[15:0];

   state_t                 state;
   logic [15:0]            cnt;
   logic [2:0]             f3_q;
   logic [1:0]             lane_q;
   logic                   bad_access;
   logic                   misaligned;
   logic [3:0]             be_c;
   logic [DATA_WIDTH-1:0]  wdata_c;
   logic [7:0]             byte_sel;
   logic [15:0]            half_sel;
   logic [DATA_WIDTH-1:0]  load_ext;

   // Decode of the incoming request, only consumed in IDLE
   always_comb begin
      bad_access = MemWrite ? (funct3 > 3'b010)
                            : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned = (funct3[1:0] == 2'b01 && ALUResult[0]) ||
                   (funct3[1:0] == 2'b10 && ALUResult[1:0] != 2'b00);
`else
      misaligned = 1'b0;
`endif
      be_c    = 4'b0000;
      wdata_c = WriteData;
      case (funct3[1:0])
         2'b00: begin
            wdata_c = {4{WriteData[7:0]}};
            be_c    = 4'b0001 << ALUResult[1:0];
         end
         2'b01: begin
            wdata_c = {2{WriteData[15:0]}};
            be_c    = ALUResult[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_c = WriteData;
            be_c    = 4'b1111;
         end
      endcase
      if (!MemWrite)
         be_c = 4'b0000;
   end

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (lane_q)
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         2'd3:    byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'h0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'h0, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         f3_q      <= '0;
         lane_q    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         ReadData  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  f3_q      <= funct3;
                  lane_q    <= ALUResult[1:0];
                  mem_we    <= MemWrite;
                  mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                  mem_wdata <= wdata_c;
                  mem_be    <= be_c;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  if (bad_access || misaligned) begin
                     state <= DONE;
                     done  <= 1'b1;
                     error <= 1'b1;
                  end else begin
                     state   <= REQ;
                     mem_req <= 1'b1;
                     error   <= 1'b0;
                  end
               end
            end
            REQ: begin
               // Ack takes priority over a timeout landing on the same cycle
               if (mem_ack) begin
                  if (!mem_we)
                     ReadData <= load_ext;
                  state   <= DONE;
                  done    <= 1'b1;
                  error   <= 1'b0;
                  mem_req <= 1'b0;
                  cnt     <= '0;
               end else if (TIMEOUT_CYCLES != 0 && cnt + 16'd1 == TIMEOUT_TC) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  error   <= 1'b1;
                  mem_req <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               error <= 1'b0;
               cnt   <= '0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
